// File: rtl/order_match_engine_pkg.sv
// Shared heap command codes and order side encodings for the order matching core.
package order_match_engine_pkg;

   typedef enum logic [1:0] {
      CMD_NOP    = 2'd0,
      CMD_PUSH   = 2'd1,
      CMD_POP    = 2'd2,
      CMD_UPDATE = 2'd3
   } heap_cmd_e;

   localparam logic SIDE_BUY  = 1'b0;
   localparam logic SIDE_SELL = 1'b1;

endpackage

// File: rtl/order_match_engine.sv
// Matching core: crosses one aggressor order against the opposite heap root, emits trades,
// and rests any residual on its own heap. ORDER_IOC_EN adds immediate-or-cancel orders.
module order_match_engine
   import order_match_engine_pkg::*;
#(
   parameter int PRICE_W = 16,
   parameter int QTY_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_side,
   input  logic [PRICE_W+QTY_W-1:0] in_order,
`ifdef ORDER_IOC_EN
   input  logic                     in_ioc,
   output logic                     cxl_valid,
   output logic [QTY_W-1:0]         cxl_qty,
`endif
   output logic [1:0]               bid_cmd,
   output logic [PRICE_W+QTY_W-1:0] bid_data,
   input  logic [PRICE_W+QTY_W-1:0] bid_root,
   input  logic                     bid_empty,
   input  logic                     bid_full,
   input  logic                     bid_done,
   output logic [1:0]               ask_cmd,
   output logic [PRICE_W+QTY_W-1:0] ask_data,
   input  logic [PRICE_W+QTY_W-1:0] ask_root,
   input  logic                     ask_empty,
   input  logic                     ask_full,
   input  logic                     ask_done,
   output logic                     trade_valid,
   output logic [PRICE_W-1:0]       trade_price,
   output logic [QTY_W-1:0]         trade_qty,
   output logic                     trade_side,
   output logic                     rej_valid,
   output logic                     busy
);

   localparam int ORDER_W = PRICE_W + QTY_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_SETTLE = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic               side_q, side_d;
   logic [PRICE_W-1:0] price_q, price_d;
   logic [QTY_W-1:0]   rem_q, rem_d;
   logic               wait_side_q, wait_side_d;
   logic               last_push_q, last_push_d;
   heap_cmd_e          bid_cmd_q, bid_cmd_d, ask_cmd_q, ask_cmd_d;
   logic [ORDER_W-1:0] bid_data_q, bid_data_d, ask_data_q, ask_data_d;
   logic               trade_valid_q, trade_valid_d;
   logic [PRICE_W-1:0] trade_price_q, trade_price_d;
   logic [QTY_W-1:0]   trade_qty_q, trade_qty_d;
   logic               trade_side_q, trade_side_d;
   logic               rej_valid_q, rej_valid_d;
   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;
`ifdef ORDER_IOC_EN
   logic               ioc_q, ioc_d;
   logic               cxl_valid_q, cxl_valid_d;
   logic [QTY_W-1:0]   cxl_qty_q, cxl_qty_d;
`endif

   logic [ORDER_W-1:0] opp_root_s;
   logic [PRICE_W-1:0] opp_price_s;
   logic [QTY_W-1:0]   opp_qty_s;
   logic               opp_empty_s, own_full_s, cross_s, done_s;
   heap_cmd_e          issue_cmd_s;
   logic [ORDER_W-1:0] issue_data_s;
   logic               issue_side_s;

   // Opposite-root crossing test and completion of the heap being waited on
   always_comb begin
      opp_root_s  = (side_q == SIDE_BUY) ? ask_root : bid_root;
      opp_empty_s = (side_q == SIDE_BUY) ? ask_empty : bid_empty;
      own_full_s  = (side_q == SIDE_BUY) ? bid_full : ask_full;
      opp_price_s = opp_root_s[ORDER_W-1:QTY_W];
      opp_qty_s   = opp_root_s[QTY_W-1:0];
      if (opp_empty_s) begin
         cross_s = 1'b0;
      end else if (side_q == SIDE_BUY) begin
         cross_s = (price_q >= opp_price_s);
      end else begin
         cross_s = (price_q <= opp_price_s);
      end
      done_s = (wait_side_q == SIDE_BUY) ? bid_done : ask_done;
   end

   // Next-state and next-output computation for the matching FSM
   always_comb begin
      state_d       = state_q;
      side_d        = side_q;
      price_d       = price_q;
      rem_d         = rem_q;
      wait_side_d   = wait_side_q;
      last_push_d   = last_push_q;
      issue_cmd_s   = CMD_NOP;
      issue_data_s  = '0;
      issue_side_s  = SIDE_BUY;
      trade_valid_d = 1'b0;
      trade_price_d = trade_price_q;
      trade_qty_d   = trade_qty_q;
      trade_side_d  = trade_side_q;
      rej_valid_d   = 1'b0;
`ifdef ORDER_IOC_EN
      ioc_d         = ioc_q;
      cxl_valid_d   = 1'b0;
      cxl_qty_d     = cxl_qty_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               side_d  = in_side;
               price_d = in_order[ORDER_W-1:QTY_W];
               rem_d   = in_order[QTY_W-1:0];
`ifdef ORDER_IOC_EN
               ioc_d   = in_ioc;
`endif
               if (in_order[QTY_W-1:0] != '0) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (cross_s) begin
               trade_valid_d = 1'b1;
               trade_price_d = opp_price_s;
               trade_side_d  = side_q;
               issue_side_s  = ~side_q;
               wait_side_d   = ~side_q;
               last_push_d   = 1'b0;
               state_d       = ST_WAIT;
               // Root outlasts the aggressor: trim it in place instead of popping
               if (opp_qty_s > rem_q) begin
                  trade_qty_d  = rem_q;
                  issue_cmd_s  = CMD_UPDATE;
                  issue_data_s = {opp_price_s, opp_qty_s - rem_q};
                  rem_d        = '0;
               end else begin
                  trade_qty_d  = opp_qty_s;
                  issue_cmd_s  = CMD_POP;
                  issue_data_s = opp_root_s;
                  rem_d        = rem_q - opp_qty_s;
               end
            end else if (rem_q != '0) begin
`ifdef ORDER_IOC_EN
               if (ioc_q) begin
                  cxl_valid_d = 1'b1;
                  cxl_qty_d   = rem_q;
                  state_d     = ST_IDLE;
               end else
`endif
               if (own_full_s) begin
                  rej_valid_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  issue_cmd_s  = CMD_PUSH;
                  issue_data_s = {price_q, rem_q};
                  issue_side_s = side_q;
                  wait_side_d  = side_q;
                  last_push_d  = 1'b1;
                  state_d      = ST_WAIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (done_s) begin
               state_d = ST_SETTLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_SETTLE: begin
            if ((rem_q == '0) || last_push_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CHECK;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      bid_cmd_d  = (issue_side_s == SIDE_BUY) ? issue_cmd_s : CMD_NOP;
      ask_cmd_d  = (issue_side_s == SIDE_SELL) ? issue_cmd_s : CMD_NOP;
      bid_data_d = (bid_cmd_d != CMD_NOP) ? issue_data_s : '0;
      ask_data_d = (ask_cmd_d != CMD_NOP) ? issue_data_s : '0;
      in_ready_d = (state_d == ST_IDLE);
      busy_d     = (state_d != ST_IDLE);
   end

   // State and registered-output flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         side_q        <= 1'b0;
         price_q       <= '0;
         rem_q         <= '0;
         wait_side_q   <= 1'b0;
         last_push_q   <= 1'b0;
         bid_cmd_q     <= CMD_NOP;
         ask_cmd_q     <= CMD_NOP;
         bid_data_q    <= '0;
         ask_data_q    <= '0;
         trade_valid_q <= 1'b0;
         trade_price_q <= '0;
         trade_qty_q   <= '0;
         trade_side_q  <= 1'b0;
         rej_valid_q   <= 1'b0;
         in_ready_q    <= 1'b1;
         busy_q        <= 1'b0;
`ifdef ORDER_IOC_EN
         ioc_q         <= 1'b0;
         cxl_valid_q   <= 1'b0;
         cxl_qty_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         side_q        <= side_d;
         price_q       <= price_d;
         rem_q         <= rem_d;
         wait_side_q   <= wait_side_d;
         last_push_q   <= last_push_d;
         bid_cmd_q     <= bid_cmd_d;
         ask_cmd_q     <= ask_cmd_d;
         bid_data_q    <= bid_data_d;
         ask_data_q    <= ask_data_d;
         trade_valid_q <= trade_valid_d;
         trade_price_q <= trade_price_d;
         trade_qty_q   <= trade_qty_d;
         trade_side_q  <= trade_side_d;
         rej_valid_q   <= rej_valid_d;
         in_ready_q    <= in_ready_d;
         busy_q        <= busy_d;
`ifdef ORDER_IOC_EN
         ioc_q         <= ioc_d;
         cxl_valid_q   <= cxl_valid_d;
         cxl_qty_q     <= cxl_qty_d;
`endif
      end
   end

   assign in_ready    = in_ready_q;
   assign busy        = busy_q;
   assign bid_cmd     = bid_cmd_q;
   assign ask_cmd     = ask_cmd_q;
   assign bid_data    = bid_data_q;
   assign ask_data    = ask_data_q;
   assign trade_valid = trade_valid_q;
   assign trade_price = trade_price_q;
   assign trade_qty   = trade_qty_q;
   assign trade_side  = trade_side_q;
   assign rej_valid   = rej_valid_q;
`ifdef ORDER_IOC_EN
   assign cxl_valid   = cxl_valid_q;
   assign cxl_qty     = cxl_qty_q;
`endif

endmodule
